// File: rtl/uart_temp_rx_pkg.sv
// Shared constants and FSM encoding for the temperature-sensor UART link.
// The transmitter uses the same frame constants.
package uart_temp_rx_pkg;

    localparam int          DEF_CLK_FREQ     = 50_000_000;
    localparam int          DEF_BAUD_RATE    = 115_200;
    localparam int          DEF_CLKS_PER_BIT = DEF_CLK_FREQ / DEF_BAUD_RATE;
    localparam int          DEF_DATA_WIDTH   = 32;
    localparam logic [7:0]  CRLF_BYTE        = 8'h0A;
    localparam logic [15:0] CRLF_WORD        = 16'h0D0A;
    localparam int          TRAILER_WIDTH    = 16;
    localparam int          TOTAL_NO_BITS    = 1 + DEF_DATA_WIDTH + TRAILER_WIDTH + 1;

    // One-hot so a single state bit can be probed directly.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a falling-edge detect on the
// synchronised value. All flops reset to 1 so reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rx_sync = sync;
    assign rx_fall = prev & ~sync;

endmodule

// File: rtl/uart_temp_rx.sv
// Receiver for the 50-bit temperature frame: start, 32-bit count LSB first,
// 16-bit CRLF trailer, stop. Reports good counts and framing errors as pulses.
module uart_temp_rx
    import uart_temp_rx_pkg::*;
#(
    parameter int          CLK_FREQ   = DEF_CLK_FREQ,
    parameter int          BAUD_RATE  = DEF_BAUD_RATE,
    parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [15:0] TRAILER    = CRLF_WORD
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  uart_rx_i,
    output logic [DATA_WIDTH-1:0] count_o,
    output logic                  count_valid_o,
    output logic                  frame_err_o,
    output logic                  busy_o,
    output rx_state_e             state_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int SHIFT_W      = DATA_WIDTH + TRAILER_WIDTH;
    localparam int BIT_W        = $clog2(SHIFT_W);

    localparam logic [8:0]       BIT_END  = 9'(CLKS_PER_BIT - 1);
    localparam logic [8:0]       HALF_END = 9'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SHIFT_W - 1);

    rx_state_e          state;
    rx_state_e          state_nx;
    logic               tick;
    logic [8:0]         baud_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [SHIFT_W-1:0] shreg;
    logic               rx_s;
    logic               rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (uart_rx_i),
        .rx_sync (rx_s),
        .rx_fall (rx_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // tick marks the sample point of the current state; a falling edge only
    // matters in IDLE, so mid-frame glitches cannot re-sync the receiver.
    always_comb begin
        state_nx = state;
        tick     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fall) state_nx = START;
            end
            START: begin
                if (baud_cnt == HALF_END) begin
                    tick     = 1'b1;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_END) begin
                    tick = 1'b1;
                    if (bit_cnt == LAST_BIT) state_nx = STOP;
                end
            end
            STOP: begin
                if (baud_cnt == BIT_END) begin
                    tick     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            count_o       <= '0;
            count_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            count_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;

            if (state == IDLE || tick || state_nx != state) baud_cnt <= '0;
            else                                            baud_cnt <= baud_cnt + 9'd1;

            if (state == START)             bit_cnt <= '0;
            else if (state == DATA && tick) bit_cnt <= bit_cnt + 1'b1;

            // Line is LSB first, so entering from the top leaves bit 0 at shreg[0].
            if (state == DATA && tick) shreg <= {rx_s, shreg[SHIFT_W-1:1]};

            if (state == STOP && tick) begin
                if (rx_s && shreg[SHIFT_W-1 -: TRAILER_WIDTH] == TRAILER) begin
                    count_o       <= shreg[DATA_WIDTH-1:0];
                    count_valid_o <= 1'b1;
                end else begin
                    frame_err_o   <= 1'b1;
                end
            end
        end
    end

    assign busy_o  = (state != IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_uart_temp_rx.sv
// Bench for uart_temp_rx: drives whole frames on the serial line and checks the
// reported counts and error pulses against an expected-event queue.
module tb_uart_temp_rx;
    import uart_temp_rx_pkg::*;

    localparam int BAUD     = 115_200;
    localparam int CPB      = 64;
    localparam int CLK_FREQ = BAUD * CPB;
    localparam int HALF     = CPB / 2;
    localparam int FRAME_W  = 50;
    localparam int LAT_VALID = 2 + HALF + 49 * CPB + 1;
    localparam int LAT_GLITCH = HALF + 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [31:0] count_o;
    logic        count_valid_o;
    logic        frame_err_o;
    logic        busy_o;
    rx_state_e   state_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int evt_cyc = 0;
    logic        prev_pulse = 1'b0;
    logic [31:0] last_good = '0;
    logic [32:0] exp_q[$];

    uart_temp_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .DATA_WIDTH (32),
        .TRAILER    (16'h0D0A)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .uart_rx_i     (uart_rx),
        .count_o       (count_o),
        .count_valid_o (count_valid_o),
        .frame_err_o   (frame_err_o),
        .busy_o        (busy_o),
        .state_o       (state_o)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    function automatic logic [FRAME_W-1:0] build_frame(input logic [31:0] cnt,
                                                       input logic [15:0] trl,
                                                       input logic        stop);
        return {stop, trl, cnt, 1'b0};
    endfunction

    task automatic drive_bits(input logic [FRAME_W-1:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            uart_rx = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [31:0] cnt, input logic [15:0] trl, input logic stop);
        if (stop && trl == 16'h0D0A) begin
            exp_q.push_back({1'b0, cnt});
            last_good = cnt;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        drive_bits(build_frame(cnt, trl, stop), FRAME_W);
    endtask

    task automatic idle_line(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // scoreboard
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset_n) begin
            if (count_valid_o && frame_err_o) check("pulse_mutex", 1, 0);
            if ((count_valid_o || frame_err_o) && prev_pulse) check("pulse_consecutive", 1, 0);
            if (count_valid_o || frame_err_o) begin
                evt_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {63'b0, count_valid_o | frame_err_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_kind", {63'b0, frame_err_o}, {63'b0, e[32]});
                    check("sb_count", {32'b0, count_o}, {32'b0, e[31:0]});
                end
            end
        end
        prev_pulse = count_valid_o | frame_err_o;
    end

    initial begin
        int t0;
        int lat;
        logic [31:0] r;

        repeat (4) @(negedge clk);
        check("rst_count", {32'b0, count_o}, 0);
        check("rst_valid", {63'b0, count_valid_o}, 0);
        check("rst_err", {63'b0, frame_err_o}, 0);
        check("rst_busy", {63'b0, busy_o}, 0);
        check("rst_state", {60'b0, state_o}, {60'b0, IDLE});
        reset_n = 1'b1;
        idle_line(5);
        check("post_rst_idle", {63'b0, busy_o}, 0);

        // good frame and its latency
        t0 = cyc;
        send_frame(32'h0000_12C4, 16'h0D0A, 1'b1);
        idle_line(CPB);
        lat = evt_cyc - t0;
        check("valid_latency", (lat >= LAT_VALID - 2 && lat <= LAT_VALID + 2) ? LAT_VALID : lat, LAT_VALID);

        // bad trailer
        send_frame(32'hDEAD_BEEF, 16'h0D0B, 1'b1);
        idle_line(CPB);

        // start glitch shorter than half a bit
        t0 = cyc;
        uart_rx = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        uart_rx = 1'b1;
        for (int k = 0; k < 10 && !busy_o; k++) @(negedge clk);
        check("glitch_busy_rise", {63'b0, busy_o}, 1);
        for (int k = 0; k < 4 * CPB && busy_o; k++) @(negedge clk);
        lat = cyc - t0;
        check("glitch_busy_fall", (lat >= LAT_GLITCH - 2 && lat <= LAT_GLITCH + 2) ? LAT_GLITCH : lat, LAT_GLITCH);
        idle_line(CPB);

        // back-to-back frames
        send_frame(32'hFFFF_FFFF, 16'h0D0A, 1'b1);
        send_frame(32'h0000_0001, 16'h0D0A, 1'b1);
        idle_line(CPB);

        // bad stop bit, then break
        send_frame(32'h0000_0005, 16'h0D0A, 1'b0);
        uart_rx = 1'b0;
        repeat (2000) @(negedge clk);
        check("break_no_busy", {63'b0, busy_o}, 0);
        idle_line(CPB);

        // random good frames
        for (int i = 0; i < 2; i++) begin
            r = $urandom_range(32'h7FFF_FFFF, 0);
            send_frame(r, 16'h0D0A, 1'b1);
            idle_line($urandom_range(CPB, 1));
        end

        // reset part-way through a frame
        drive_bits(build_frame(32'h1234_5678, 16'h0D0A, 1'b1), 20);
        reset_n = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        check("midrst_count", {32'b0, count_o}, 0);
        check("midrst_busy", {63'b0, busy_o}, 0);
        check("midrst_state", {60'b0, state_o}, {60'b0, IDLE});
        last_good = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle_line(CPB);
        send_frame(32'h0000_0A5A, 16'h0D0A, 1'b1);
        idle_line(2 * CPB);

        check("sb_drain", exp_q.size(), 0);
        check("final_count", {32'b0, count_o}, {32'b0, 32'h0000_0A5A});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
